usb_tx_buffer: RTL

//  Owns the 4-bank TX packet RAM that cmd_decode writes (tx_vd/tx_addr/tx_data), one

---
 rtl/usb_tx_buffer_pkg.sv | 26 ++
 rtl/usb_tx_buffer_if.sv | 28 ++
 rtl/usb_tx_buffer_bank_fifo.sv | 80 ++++++++
 rtl/usb_tx_buffer.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/usb_tx_buffer_pkg.sv
// Shared widths, state encoding and small helpers for the USB TX packet buffer.
// Included by the interface, the bank queue and the top.
package usb_tx_buffer_pkg;

    localparam int DATA_NBIT        = 16;
    localparam int ADDR_NBIT        = 8;
    localparam int BADDR_NBIT       = 2;
    localparam int BUFFER_ADDR_NBIT = BADDR_NBIT + ADDR_NBIT;
    localparam int QDEPTH           = 4;
    localparam int NWORD            = 2 ** BUFFER_ADDR_NBIT;

    localparam logic [ADDR_NBIT-1:0] WORD_ONE = ADDR_NBIT'(1);

    typedef enum logic [1:0] {
        TXB_IDLE = 2'd0,
        TXB_LOAD = 2'd1,
        TXB_SEND = 2'd2,
        TXB_PEND = 2'd3
    } txb_state_e;

    // The word counter wraps to zero after the final word of a bank.
    function automatic logic is_last_word(input logic [ADDR_NBIT-1:0] word);
        return &word;
    endfunction

endpackage

// File: rtl/usb_tx_buffer_if.sv
// Bundle of the cmd_decode write side and the USB slave-FIFO write side.
// The master modport is the environment, the slave modport is the buffer.
interface usb_tx_buffer_if;
    import usb_tx_buffer_pkg::*;

    logic                        tx_vd;
    logic [BUFFER_ADDR_NBIT-1:0] tx_addr;
    logic [DATA_NBIT-1:0]        tx_data;
    logic                        tx_eop;
    logic [BADDR_NBIT-1:0]       tx_baddr;
    logic                        usb_full;
    logic                        usb_wr;
    logic [DATA_NBIT-1:0]        usb_wdata;
    logic                        usb_pktend;
    logic                        tx_busy;
    logic                        tx_ovf;

    modport master (
        output tx_vd, tx_addr, tx_data, tx_eop, tx_baddr, usb_full,
        input  usb_wr, usb_wdata, usb_pktend, tx_busy, tx_ovf
    );

    modport slave (
        input  tx_vd, tx_addr, tx_data, tx_eop, tx_baddr, usb_full,
        output usb_wr, usb_wdata, usb_pktend, tx_busy, tx_ovf
    );

endinterface

// File: rtl/usb_tx_buffer_bank_fifo.sv
// Small synchronous FIFO of completed bank numbers. A push into a full queue is
// still taken when a pop happens in the same cycle; otherwise it is dropped and flagged.
module usb_tx_buffer_bank_fifo
    import usb_tx_buffer_pkg::*;
#(
    parameter int DEPTH = QDEPTH,
    parameter int WIDTH = BADDR_NBIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic             push_drop
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [PW:0]   CNT_ONE = (PW + 1)'(1);
    localparam logic [PW:0]   CNT_MAX = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             do_push_s, do_pop_s;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_MAX);
    assign dout  = mem_q[rd_ptr_q];

    // Accept/drop decision and next pointer/count values.
    always_comb begin
        do_pop_s  = pop & ~empty;
        do_push_s = push & (~full | do_pop_s);
        push_drop = push & ~do_push_s;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Queue storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/usb_tx_buffer.sv
// Four-bank TX packet RAM written by cmd_decode and drained bank-by-bank into the
// USB slave FIFO, one pktend per bank, in the order the banks were completed.
module usb_tx_buffer
    import usb_tx_buffer_pkg::*;
(
    input  logic           mclk,
    input  logic           rst_n,
    usb_tx_buffer_if.slave bus
);

    logic [DATA_NBIT-1:0]        mem [NWORD];
    logic [DATA_NBIT-1:0]        rdata_q;

    txb_state_e                  state_q, state_d;
    logic [BADDR_NBIT-1:0]       bank_q, bank_d;
    logic [ADDR_NBIT-1:0]        word_q, word_d;
    logic                        out_valid_q, out_valid_d;
    logic                        ovf_q, ovf_d;

    logic                        pop_s;
    logic                        rd_en_s;
    logic                        usb_wr_s;
    logic                        pktend_s;
    logic [ADDR_NBIT-1:0]        rd_word_s;
    logic [BUFFER_ADDR_NBIT-1:0] rd_addr_s;
    logic                        q_empty_s, q_full_s, q_drop_s;
    logic [BADDR_NBIT-1:0]       q_dout_s;

    usb_tx_buffer_bank_fifo #(
        .DEPTH (QDEPTH),
        .WIDTH (BADDR_NBIT)
    ) u_bank_fifo (
        .clk       (mclk),
        .rst_n     (rst_n),
        .push      (bus.tx_eop),
        .din       (bus.tx_baddr),
        .pop       (pop_s),
        .dout      (q_dout_s),
        .empty     (q_empty_s),
        .full      (q_full_s),
        .push_drop (q_drop_s)
    );

    assign rd_addr_s      = {bank_q, rd_word_s};
    assign bus.usb_wr     = usb_wr_s;
    assign bus.usb_wdata  = rdata_q;
    assign bus.usb_pktend = pktend_s;
    assign bus.tx_busy    = ~q_empty_s | (state_q != TXB_IDLE);
    assign bus.tx_ovf     = ovf_q;

    // Sequencer. In SEND the RAM re-reads the current word while stalled and reads
    // the following word on each accept, so rdata_q always holds word_q.
    always_comb begin
        state_d     = state_q;
        bank_d      = bank_q;
        word_d      = word_q;
        out_valid_d = out_valid_q;
        pop_s       = 1'b0;
        rd_en_s     = 1'b0;
        rd_word_s   = word_q;
        usb_wr_s    = 1'b0;
        pktend_s    = 1'b0;
        ovf_d       = ovf_q | q_drop_s;
        case (state_q)
            TXB_IDLE: begin
                if (!q_empty_s) begin
                    pop_s   = 1'b1;
                    bank_d  = q_dout_s;
                    word_d  = '0;
                    state_d = TXB_LOAD;
                end else begin
                    state_d = TXB_IDLE;
                end
            end
            TXB_LOAD: begin
                rd_en_s     = 1'b1;
                out_valid_d = 1'b1;
                state_d     = TXB_SEND;
            end
            TXB_SEND: begin
                rd_en_s  = 1'b1;
                usb_wr_s = out_valid_q & ~bus.usb_full;
                if (usb_wr_s) begin
                    rd_word_s = word_q + WORD_ONE;
                    word_d    = word_q + WORD_ONE;
                    if (is_last_word(word_q)) begin
                        out_valid_d = 1'b0;
                        state_d     = TXB_PEND;
                    end else begin
                        state_d = TXB_SEND;
                    end
                end else begin
                    rd_word_s = word_q;
                end
            end
            TXB_PEND: begin
                pktend_s = 1'b1;
                state_d  = TXB_IDLE;
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = TXB_IDLE;
            end
        endcase
    end

    // Packet RAM write port, independent of the reader.
    always_ff @(posedge mclk) begin
        if (bus.tx_vd) begin
            mem[bus.tx_addr] <= bus.tx_data;
        end
    end

    // Synchronous RAM read register, which is also the USB data output.
    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (rd_en_s) begin
            rdata_q <= mem[rd_addr_s];
        end
    end

    // Sequencer and status registers.
    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            state_q     <= TXB_IDLE;
            bank_q      <= '0;
            word_q      <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bank_q      <= bank_d;
            word_q      <= word_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
        end
    end

endmodule
